// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    ITER,
    FIX
  } state_t;

  function automatic logic [31:0] MIN_VAL(input int unsigned w);
    return 32'h1 << (w - 1);
  endfunction

  function automatic logic [31:0] MAX_VAL(input int unsigned w);
    return (32'h1 << (w - 1)) - 32'h1;
  endfunction

  // Two's-complement negate when neg is set; callers size-cast the result.
  function automatic logic [32:0] cond_neg(input logic [32:0] x, input logic neg);
    return neg ? (~x + 33'd1) : x;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_restore_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] rem_i,
  input  logic           bit_i,
  input  logic [WIDTH:0] dmag_i,
  output logic [WIDTH:0] rem_o,
  output logic           qbit_o
);

  logic [WIDTH+1:0] shifted;

  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = (shifted >= {1'b0, dmag_i});
    rem_o   = qbit_o ? (WIDTH+1)'(shifted - {1'b0, dmag_i}) : shifted[WIDTH:0];
  end

endmodule

// File: rtl/signed_div_seq.sv
// Sequential signed divider, one quotient bit per cycle, truncating toward zero.
// Define SIGNED_DIV_SAT_EN to saturate quotients on overflow / divide-by-zero.
module signed_div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL(WIDTH));
`ifdef SIGNED_DIV_SAT_EN
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL(WIDTH));
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic [WIDTH:0]   dmag_q, dmag_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             ov_q, ov_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_rem;
  logic             step_qbit;

  // quo_q starts as the dividend magnitude and shifts left, quotient bits entering at the LSB.
  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .bit_i  (quo_q[WIDTH-1]),
    .dmag_i (dmag_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dmag_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dmag_q  <= dmag_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dmag_d  = dmag_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          sq_d    = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sr_d    = dividend[WIDTH-1];
          dz_d    = 1'b0;
          ov_d    = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        if (dvs_q == '0) begin
          dz_d    = 1'b1;
`ifdef SIGNED_DIV_SAT_EN
          q_d     = dvd_q[WIDTH-1] ? MIN_W : MAX_W;
`else
          q_d     = '1;
`endif
          r_d     = dvd_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // |MIN| = 2^(WIDTH-1) still fits in WIDTH unsigned bits.
          quo_d   = WIDTH'(cond_neg(33'(signed'(dvd_q)), dvd_q[WIDTH-1]));
          dmag_d  = (WIDTH+1)'(cond_neg(33'(signed'(dvs_q)), dvs_q[WIDTH-1]));
          rem_d   = '0;
          ov_d    = (dvd_q == MIN_W) && (dvs_q == '1);
          cnt_d   = CNT_W'(WIDTH);
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        q_d     = WIDTH'(cond_neg(33'(quo_q), sq_q));
        r_d     = WIDTH'(cond_neg(33'(rem_q), sr_q));
`ifdef SIGNED_DIV_SAT_EN
        if (ov_q) begin
          q_d = MAX_W;
        end
`endif
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign q        = q_q;
  assign r        = r_q;
  assign div_zero = dz_q;
  assign overflow = ov_q;

endmodule

// File: tb/tb_signed_div_seq.sv
// Scoreboard bench for signed_div_seq at WIDTH=4 and WIDTH=8.
module tb_signed_div_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       st4, bz4, dn4, dz4, ov4;
  logic [3:0] a4, b4, q4, r4;
  logic       st8, bz8, dn8, dz8, ov8;
  logic [7:0] a8, b8, q8, r8;

  signed_div_seq #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .dividend(a4), .divisor(b4),
    .busy(bz4), .done(dn4), .q(q4), .r(r4), .div_zero(dz4), .overflow(ov4)
  );

  signed_div_seq #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .dividend(a8), .divisor(b8),
    .busy(bz8), .done(dn8), .q(q8), .r(r8), .div_zero(dz8), .overflow(ov8)
  );

  typedef struct {
    int q;
    int r;
    bit dz;
    bit ov;
    int lat;
    int t0;
  } exp_t;

  exp_t sb4[$];
  exp_t sb8[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division (truncating) plus the special-case rules.
  function automatic exp_t model(input int w, input int a, input int b);
    exp_t e;
    int mn, mx;
    mn = -(1 << (w - 1));
    mx = (1 << (w - 1)) - 1;
    e.dz = 0;
    e.ov = 0;
    e.t0 = 0;
    e.lat = w + 2;
    if (b == 0) begin
      e.dz  = 1;
      e.lat = 1;
`ifdef SIGNED_DIV_SAT_EN
      e.q = (a < 0) ? mn : mx;
`else
      e.q = -1;
`endif
      e.r = a;
    end else if (a == mn && b == -1) begin
      e.ov = 1;
`ifdef SIGNED_DIV_SAT_EN
      e.q = mx;
`else
      e.q = mn;
`endif
      e.r = 0;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic judge(input int sel, input logic [31:0] qa, input logic [31:0] ra,
                       input logic dza, input logic ova, input logic bza);
    exp_t e;
    bit have;
    int w;
    logic [31:0] mask;
    w = (sel == 0) ? 4 : 8;
    mask = (32'h1 << w) - 32'h1;
    have = 0;
    if (sel == 0) begin
      if (sb4.size() > 0) begin e = sb4.pop_front(); have = 1; end
    end else begin
      if (sb8.size() > 0) begin e = sb8.pop_front(); have = 1; end
    end
    if (!have) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done: w=%0d got done=1 expected no done (t=%0t)", w, $time);
    end else begin
      chk($sformatf("q_w%0d", w), qa, 32'(e.q) & mask);
      chk($sformatf("r_w%0d", w), ra, 32'(e.r) & mask);
      chk($sformatf("div_zero_w%0d", w), 32'(dza), 32'(e.dz));
      chk($sformatf("overflow_w%0d", w), 32'(ova), 32'(e.ov));
      chk($sformatf("busy_at_done_w%0d", w), 32'(bza), 32'd0);
      chk($sformatf("latency_w%0d", w), 32'(cyc - e.t0), 32'(e.lat + 1));
    end
  endtask

  always @(negedge clk) begin
    if (!rst && dn4) judge(0, 32'(q4), 32'(r4), dz4, ov4, bz4);
    if (!rst && dn8) judge(1, 32'(q8), 32'(r8), dz8, ov8, bz8);
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic issue(input int sel, input int a, input int b, input bit push);
    exp_t e;
    int n;
    n = 0;
    while (((sel == 0) ? bz4 : bz8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: sel=%0d got busy=1 expected busy=0", sel);
    end
    if (sel == 0) begin
      a4 = 4'(a); b4 = 4'(b); st4 = 1'b1;
    end else begin
      a8 = 8'(a); b8 = 8'(b); st8 = 1'b1;
    end
    if (push) begin
      e = model((sel == 0) ? 4 : 8, a, b);
      e.t0 = cyc;
      if (sel == 0) sb4.push_back(e);
      else sb8.push_back(e);
    end
    @(negedge clk);
    st4 = 1'b0;
    st8 = 1'b0;
    a4 = 4'($urandom);
    b4 = 4'($urandom);
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    chk("busy_after_start", 32'((sel == 0) ? bz4 : bz8), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb4.size() > 0 || sb8.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb4.size() + sb8.size());
    end
  endtask

  int dir_a[7] = '{7, -7, 7, -7, -8, 5, -3};
  int dir_b[7] = '{2, 2, -2, -2, -1, 0, 0};
  int c8_a[8]  = '{-128, -128, 127, -128, 100, -1, 0, -77};
  int c8_b[8]  = '{-1, 1, -128, 0, 0, -1, -5, 127};

  initial begin
    rst = 1'b1;
    st4 = 1'b0; a4 = '0; b4 = '0;
    st8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_q4", 32'(q4), 32'd0);
    chk("rst_r4", 32'(r4), 32'd0);
    chk("rst_flags4", 32'({bz4, dn4, dz4, ov4}), 32'd0);
    chk("rst_q8", 32'(q8), 32'd0);
    chk("rst_flags8", 32'({bz8, dn8, dz8, ov8}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed WIDTH=4 cases, issued back-to-back with the previous done.
    for (int i = 0; i < 7; i++) issue(0, dir_a[i], dir_b[i], 1);

    // A start pulse while busy must be ignored.
    issue(0, 7, 2, 1);
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd1; st4 = 1'b1;
    @(negedge clk);
    st4 = 1'b0;
    issue(0, 6, 3, 1);
    issue(0, -5, 2, 1);
    drain();

    // Reset in the middle of an iteration aborts with no done.
    issue(0, 7, 3, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_q4", 32'(q4), 32'd0);
    chk("midrst_r4", 32'(r4), 32'd0);
    chk("midrst_flags4", 32'({bz4, dn4, dz4, ov4}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Exhaustive WIDTH=4.
    for (int a = -8; a < 8; a++)
      for (int b = -8; b < 8; b++)
        issue(0, a, b, 1);
    drain();

    // WIDTH=8 corners then random operands, zero and -1 divisors favoured.
    for (int i = 0; i < 8; i++) issue(1, c8_a[i], c8_b[i], 1);
    for (int i = 0; i < 1500; i++) begin
      int a, b, sel;
      a = int'($urandom_range(0, 255)) - 128;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) b = 0;
      else if (sel == 1) b = -1;
      else b = int'($urandom_range(0, 255)) - 128;
      if (sel == 2) a = -128;
      issue(1, a, b, 1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
